// File: rtl/mul_add_pair_scheduler_pkg.sv
// Shared widths and types for the paired multiply-add scheduler.
package mac_pair_pkg;

  localparam int A_W   = 27;
  localparam int B_W   = 18;
  localparam int C_W   = 48;
  localparam int TAG_W = 8;
  localparam int RET_W = 2 * C_W;

  typedef struct packed {
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [C_W-1:0]   c;
    logic [TAG_W-1:0] tag;
  } lane_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pair_state_e;

  typedef struct packed {
    logic             v0;
    logic             v1;
    logic [TAG_W-1:0] tag0;
    logic [TAG_W-1:0] tag1;
  } inflight_t;

  function automatic int lanes_of(input inflight_t e);
    return int'(e.v0) + int'(e.v1);
  endfunction

endpackage

// File: rtl/mul_add_pair_scheduler_if.sv
// Request stream, paired-unit bus and result stream of the scheduler.
interface mul_add_pair_scheduler_if;
  import mac_pair_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [A_W-1:0]   s_a;
  logic [B_W-1:0]   s_b;
  logic [C_W-1:0]   s_c;
  logic [TAG_W-1:0] s_tag;
  logic             s_last;

  logic             pu_ce;
  logic [A_W-1:0]   pu_a0, pu_a1;
  logic [B_W-1:0]   pu_b0, pu_b1;
  logic [C_W-1:0]   pu_c0, pu_c1;
  logic [RET_W-1:0] pu_return;

  logic             m_valid;
  logic             m_ready;
  logic [C_W-1:0]   m_dout;
  logic [TAG_W-1:0] m_tag;

  modport master (
    output s_valid, s_a, s_b, s_c, s_tag, s_last, pu_return, m_ready,
    input  s_ready, pu_ce, pu_a0, pu_a1, pu_b0, pu_b1, pu_c0, pu_c1,
           m_valid, m_dout, m_tag
  );

  modport slave (
    input  s_valid, s_a, s_b, s_c, s_tag, s_last, pu_return, m_ready,
    output s_ready, pu_ce, pu_a0, pu_a1, pu_b0, pu_b1, pu_c0, pu_c1,
           m_valid, m_dout, m_tag
  );

endinterface

// File: rtl/mul_add_pair_scheduler_fifo.sv
// Result FIFO taking up to two writes (lane 0 before lane 1) and one read per cycle.
module mac_pair_result_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 56,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr0_en_i,
  input  logic [W-1:0]     wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [W-1:0]     wr1_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] free_count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q, wptr_nxt;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       num_wr;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop          = rd_en_i && (count_q != '0);
  assign num_wr       = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
  assign wptr_nxt     = ptr_inc(wptr_q);
  assign rd_valid_o   = (count_q != '0);
  assign rd_data_o    = rd_valid_o ? mem_q[rptr_q] : '0;
  assign free_count_o = CNT_W'(DEPTH) - count_q;

  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wptr_q] <= wr0_data_i;
    if (wr1_en_i) begin
      if (wr0_en_i) mem_q[wptr_nxt] <= wr1_data_i;
      else          mem_q[wptr_q]   <= wr1_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (num_wr == 2'd2)      wptr_q <= ptr_inc(wptr_nxt);
      else if (num_wr == 2'd1) wptr_q <= wptr_nxt;
      if (pop) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CNT_W'(num_wr) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/mul_add_pair_scheduler.sv
// Packs requests into lane pairs for the double-pumped mul-add unit and returns tagged results in order.
// Optional idle flush of a lone held request is enabled by defining MAC_PAIR_FLUSH_EN.
module mul_add_pair_scheduler
  import mac_pair_pkg::*;
#(
  parameter int LATENCY       = 4,
  parameter int OUT_DEPTH     = 16,
  parameter int FLUSH_TIMEOUT = 8
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  mul_add_pair_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  if (LATENCY < 1 || OUT_DEPTH < 2 * LATENCY + 4 || FLUSH_TIMEOUT < 1) begin : g_param_check
    $error("mul_add_pair_scheduler: illegal LATENCY/OUT_DEPTH/FLUSH_TIMEOUT");
  end

  pair_state_e      state_q, state_d;
  lane_t            hold_q, hold_d, req, lane0, lane1;
  inflight_t        trk_q [LATENCY];
  inflight_t        trk_in, trk_exit;
  logic             ce_q, rdy_q, accept, issue, lane1_valid, flush;
  logic [A_W-1:0]   pu_a0_q, pu_a1_q;
  logic [B_W-1:0]   pu_b0_q, pu_b1_q;
  logic [C_W-1:0]   pu_c0_q, pu_c1_q;
  logic [CNT_W-1:0] free_count;
  logic [TAG_W+C_W-1:0] fifo_dout;
  int               inflight_lanes, credit;

  assign req    = '{a: bus.s_a, b: bus.s_b, c: bus.s_c, tag: bus.s_tag};
  assign accept = bus.s_valid && bus.s_ready;

  // Every accepted request must already own a FIFO slot, so pu_ce never stalls.
  always_comb begin
    inflight_lanes = 0;
    for (int i = 0; i < LATENCY; i++) inflight_lanes += lanes_of(trk_q[i]);
    credit = int'(free_count) - inflight_lanes - ((state_q == HALF) ? 1 : 0);
  end

  assign bus.s_ready = rdy_q && (credit >= 2);

`ifdef MAC_PAIR_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    flush  = 1'b0;
    if (state_q == HALF && !accept) begin
      if (idle_q == IDLE_W'(FLUSH_TIMEOUT - 1)) flush = 1'b1;
      else                                      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    issue       = 1'b0;
    lane1_valid = 1'b0;
    lane0       = hold_q;
    lane1       = '0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (bus.s_last) begin
            issue = 1'b1;
            lane0 = req;
          end else begin
            hold_d  = req;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          issue       = 1'b1;
          lane1       = req;
          lane1_valid = 1'b1;
          state_d     = EMPTY;
        end else if (flush) begin
          issue   = 1'b1;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    trk_in = issue ? '{v0: 1'b1, v1: lane1_valid, tag0: lane0.tag, tag1: lane1.tag} : '0;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      ce_q    <= 1'b0;
      rdy_q   <= 1'b0;
      pu_a0_q <= '0;
      pu_a1_q <= '0;
      pu_b0_q <= '0;
      pu_b1_q <= '0;
      pu_c0_q <= '0;
      pu_c1_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ce_q    <= 1'b1;
      rdy_q   <= ce_q;
      if (issue) begin
        pu_a0_q <= lane0.a;
        pu_a1_q <= lane1.a;
        pu_b0_q <= lane0.b;
        pu_b1_q <= lane1.b;
        pu_c0_q <= lane0.c;
        pu_c1_q <= lane1.c;
      end
    end
  end

  // Tracker advances in lock-step with the unit pipeline; its last stage aligns with pu_return.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < LATENCY; i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= trk_in;
      for (int i = 1; i < LATENCY; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  assign trk_exit = trk_q[LATENCY-1];

  mac_pair_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (TAG_W + C_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (ap_clk),
    .rst          (ap_rst),
    .wr0_en_i     (trk_exit.v0),
    .wr0_data_i   ({trk_exit.tag0, bus.pu_return[RET_W-1:C_W]}),
    .wr1_en_i     (trk_exit.v1),
    .wr1_data_i   ({trk_exit.tag1, bus.pu_return[C_W-1:0]}),
    .rd_en_i      (bus.m_ready),
    .rd_data_o    (fifo_dout),
    .rd_valid_o   (bus.m_valid),
    .free_count_o (free_count)
  );

  assign bus.m_dout = fifo_dout[C_W-1:0];
  assign bus.m_tag  = fifo_dout[C_W +: TAG_W];
  assign bus.pu_ce  = ce_q;
  assign bus.pu_a0  = pu_a0_q;
  assign bus.pu_a1  = pu_a1_q;
  assign bus.pu_b0  = pu_b0_q;
  assign bus.pu_b1  = pu_b1_q;
  assign bus.pu_c0  = pu_c0_q;
  assign bus.pu_c1  = pu_c1_q;

endmodule

// File: doc/mul_add_pair_scheduler.md
# mul_add_pair_scheduler

Issue-side scheduler and result collector for the double-pumped paired multiply-add unit (two `a*b+c` lanes sharing one DSP). Accepts single multiply-add requests on a valid/ready stream, packs consecutive requests into lane 0 and lane 1 of one issue, and tracks in-flight pairs through the unit's fixed latency. It then unpacks the 96-bit return into an in-order, tagged result stream with backpressure. It sits between HLS-generated request producers and the paired unit in the same `ap_clk` domain.

## Interface
- `A_W`, 27, multiplicand width (signed)
- `B_W`, 18, multiplier width (signed)
- `C_W`, 48, addend/result width (signed)
- `TAG_W`, 8, request tag width
- `LATENCY`, 4, `ap_clk` cycles from issue to valid `pu_return`; must be ≥1
- `OUT_DEPTH`, 16, result FIFO entries; must be ≥ 2*LATENCY+4
- `FLUSH_TIMEOUT`, 8, idle cycles before a lone request issues (see Configuration)
- `ap_clk`  in  1  sole clock
- `ap_rst`  in  1  reset, asynchronous, active-high
- `s_valid`  in  1  request valid
- `s_ready`  out  1  request accepted when `s_valid & s_ready`
- `s_a`  in  A_W; `s_b`  in  B_W; `s_c`  in  C_W  operands
- `s_tag`  in  TAG_W  returned unchanged with the result
- `s_last`  in  1  forces issue of this request without waiting for a partner
- `pu_ce`  out  1  clock enable to paired unit
- `pu_a0`, `pu_a1`  out  A_W; `pu_b0`, `pu_b1`  out  B_W; `pu_c0`, `pu_c1`  out  C_W  lane operands, registered
- `pu_return`  in  96  bits [95:48] lane-0 result, [47:0] lane-1 result
- `m_valid`  out  1; `m_ready`  in  1  result handshake
- `m_dout`  out  C_W  result; `m_tag`  out  TAG_W  result tag

## Operation
- Pairing FSM: EMPTY, HALF.
  - EMPTY + accept, `s_last`=0: latch request into the hold register, go HALF.
  - EMPTY + accept, `s_last`=1: issue it on lane 0 with lane 1 idle; stay EMPTY.
  - HALF + accept: issue held request on lane 0 and new request on lane 1; go EMPTY. `s_last` is irrelevant here.
  - HALF, no accept: idle counter increments; flush behaviour is defined under Configuration.
- Idle lane operands are all zero. The lane is marked invalid and its result is discarded.
- Issue loads `pu_*` registers. A LATENCY-deep shift register carries {lane0_valid, lane1_valid, tag0, tag1} in step with the unit.
- On tracker exit, the valid lanes of `pu_return` are written to the result FIFO (`mac_pair_result_fifo`, 2 writes/1 read per cycle). Write order is lane 0 first, then lane 1.
- Output order equals acceptance order.
- Credit rule: `s_ready` = (free FIFO slots − valid lanes in flight − held lanes) ≥ 2. This guarantees the FIFO never overflows, so `pu_ce` never has to stall.
- `pu_ce` is 0 during reset and 1 from the first cycle after reset release.
- Arithmetic is done in the unit. The scheduler passes `pu_return` lanes through unmodified, with no sign extension or truncation.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `pu_ce`=0, all `pu_*` operands 0, `m_dout`/`m_tag` 0. FSM EMPTY, counter 0, FIFO empty, tracker cleared.
- First `s_ready`=1 is in the second cycle after reset deassertion.
- Issue happens at edge t (pairing accept or flush). `pu_return` is sampled at edge t+LATENCY. `m_valid` rises after edge t+LATENCY, so minimum accept-to-`m_valid` is LATENCY+1 cycles.
- The second result of a pair appears one cycle after the first if `m_ready`=1.
- `m_valid` stays high and `m_dout`/`m_tag` stay stable until `m_ready`.
- Simultaneous FIFO push and pop in the same cycle are both performed.
- If a request is accepted in HALF in the same cycle the flush timeout expires, pairing wins.
- Reset mid-operation discards held, in-flight, and buffered results. No partial results are emitted.

## Configuration
- Macro: `MAC_PAIR_FLUSH_EN`.
- Defined: in HALF, after FLUSH_TIMEOUT consecutive cycles with no accept, the held request issues alone and the FSM goes EMPTY. The counter resets on every accept.
- Undefined: the held request waits indefinitely for a partner or an `s_last` request. The counter logic is not built.

## Structure
- Package `mac_pair_pkg`:
  - default width constants
  - `lane_t` struct {a, b, c, tag}
  - `pair_state_e` enum {EMPTY, HALF}
  - `inflight_t` struct for tracker entries
- Sub-module `mac_pair_result_fifo`: 2-write/1-read synchronous FIFO with `free_count` output.

## Test plan
- Two back-to-back requests (a=3, b=−2, c=10, tag 1) and (a=−5, b=4, c=0, tag 2), model unit returns a*b+c. Expect `pu_a0`=3, `pu_a1`=−5 on one issue; outputs 4/tag1 then −20/tag2; first `m_valid` at LATENCY+1 cycles.
- Single request with `s_last`=1 (a=7, b=7, c=1, tag 9). Expect lane-1 operands zero and exactly one output 50/tag9.
- Single request, `s_last`=0, no follow-up. With `MAC_PAIR_FLUSH_EN`: issue after 8 idle cycles and output emitted. Without the macro: no issue after 100 cycles.
- Hold `m_ready`=0 while streaming 40 requests. `s_ready` must drop before the FIFO overflows. Release `m_ready`: all 40 results appear in order with correct tags and no loss.
- Assert `ap_rst` while 3 pairs are in flight. Outputs return to reset values immediately; after release, no stale results appear and a new pair completes normally.
- Random valid/ready traffic for 10k requests with random `s_last`. Scoreboard checks in-order values and tags.
